mmio_peripheral_bus: RTL and testbench

//  CPU data-port slave for the I/O window (DatenAdresse[31]==1); data RAM serves the rest of the address space.

---
 rtl/mmio_peripheral_bus.sv | 213 +++++++++++++++++++++
 tb/tb_mmio_peripheral_bus.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_peripheral_bus.sv
// I/O-window slave for the CPU data port: LED register, buffered 8N1 UART transmitter
// and a free-running cycle counter, with one-cycle registered acknowledges.
module mmio_peripheral_bus #(
   parameter int CLOCK_HZ   = 4000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_TIEFE = 8
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Auswahl,
   input  logic [1:0]  Adresse,
   input  logic        LeseDaten,
   input  logic        SchreibeDaten,
   input  logic [31:0] DatenRein,
   output logic [31:0] DatenRaus,
   output logic        DatenGeladen,
   output logic        DatenGespeichert,
   output logic [7:0]  led,
   output logic        Tx
);

   localparam int TEILER = CLOCK_HZ / BAUD;
   localparam int TW     = (TEILER > 1) ? $clog2(TEILER) : 1;
   localparam int AW     = $clog2(FIFO_TIEFE);
   localparam int CW     = AW + 1;
   localparam logic [TW-1:0] TEILER_MAX = TW'(TEILER - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_zustand_t;

   uart_zustand_t zustand_q, zustand_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic [7:0]    mem_q [FIFO_TIEFE];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    led_q, led_d;
   logic [31:0]   zaehler_q, zaehler_d;
   logic [31:0]   raus_q, raus_d;
   logic          ack_lesen_q, ack_schreib_q;
   logic          warte_q, warte_d;

   logic          voll_s, leer_s, pop_s, push_s;
   logic          schreib_s, lese_s, wr_ok_s, rd_ok_s;
   logic [31:0]   status_s;
   logic          unused_s;

   assign unused_s  = ^DatenRein[31:8];
   assign voll_s    = (count_q == CW'(FIFO_TIEFE));
   assign leer_s    = (count_q == {CW{1'b0}});
   assign pop_s     = (zustand_q == IDLE) && !leer_s;
   // A write has priority over a simultaneous read; a UART write may use the slot freed by a pop.
   assign schreib_s = Auswahl && SchreibeDaten;
   assign lese_s    = Auswahl && LeseDaten && !SchreibeDaten;
   assign wr_ok_s   = schreib_s && !warte_q && ((Adresse != 2'd1) || !voll_s || pop_s);
   assign rd_ok_s   = lese_s && !warte_q;
   assign push_s    = wr_ok_s && (Adresse == 2'd1);

   // Bus side: register writes, read mux, counter and the drop-before-next-request guard.
   always_comb begin
      led_d     = led_q;
      zaehler_d = zaehler_q + 32'd1;
      raus_d    = 32'd0;
      warte_d   = warte_q;
      status_s  = 32'd0;
      status_s[0]       = voll_s;
      status_s[1]       = leer_s;
      status_s[2]       = (zustand_q != IDLE);
      status_s[8 +: CW] = count_q;
      if (wr_ok_s) begin
         case (Adresse)
            2'd0:    led_d     = DatenRein[7:0];
            2'd3:    zaehler_d = 32'd0;
            default: led_d     = led_q;
         endcase
      end else begin
         led_d = led_q;
      end
      if (rd_ok_s) begin
         case (Adresse)
            2'd0:    raus_d = {24'd0, led_q};
            2'd3:    raus_d = zaehler_q;
            default: raus_d = status_s;
         endcase
      end else begin
         raus_d = 32'd0;
      end
      if (wr_ok_s || rd_ok_s) begin
         warte_d = 1'b1;
      end else if (!(Auswahl && (LeseDaten || SchreibeDaten))) begin
         warte_d = 1'b0;
      end else begin
         warte_d = warte_q;
      end
   end

   // FIFO pointer and occupancy update.
   always_comb begin
      wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // UART transmit FSM; Tx is registered from the next state so it changes with the state.
   always_comb begin
      zustand_d = zustand_q;
      timer_d   = timer_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      case (zustand_q)
         IDLE: begin
            timer_d = {TW{1'b0}};
            bit_d   = 3'd0;
            if (pop_s) begin
               shift_d   = mem_q[rd_ptr_q];
               zustand_d = START;
            end else begin
               zustand_d = IDLE;
            end
         end
         START: begin
            if (timer_q == TEILER_MAX) begin
               timer_d   = {TW{1'b0}};
               zustand_d = DATA;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DATA: begin
            if (timer_q == TEILER_MAX) begin
               timer_d = {TW{1'b0}};
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_d     = 3'd0;
                  zustand_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         STOP: begin
            if (timer_q == TEILER_MAX) begin
               timer_d   = {TW{1'b0}};
               zustand_d = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: zustand_d = IDLE;
      endcase
      case (zustand_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // State registers; reset empties the FIFO and forces the line idle.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         zustand_q     <= IDLE;
         timer_q       <= {TW{1'b0}};
         bit_q         <= 3'd0;
         shift_q       <= 8'd0;
         tx_q          <= 1'b1;
         wr_ptr_q      <= {AW{1'b0}};
         rd_ptr_q      <= {AW{1'b0}};
         count_q       <= {CW{1'b0}};
         led_q         <= 8'd0;
         zaehler_q     <= 32'd0;
         raus_q        <= 32'd0;
         ack_lesen_q   <= 1'b0;
         ack_schreib_q <= 1'b0;
         warte_q       <= 1'b0;
      end else begin
         zustand_q     <= zustand_d;
         timer_q       <= timer_d;
         bit_q         <= bit_d;
         shift_q       <= shift_d;
         tx_q          <= tx_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         led_q         <= led_d;
         zaehler_q     <= zaehler_d;
         raus_q        <= raus_d;
         ack_lesen_q   <= rd_ok_s;
         ack_schreib_q <= wr_ok_s;
         warte_q       <= warte_d;
      end
   end

   // FIFO storage; contents are only meaningful between the pointers, so no reset.
   always_ff @(posedge Clock) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= DatenRein[7:0];
      end
   end

   assign DatenRaus        = raus_q;
   assign DatenGeladen     = ack_lesen_q;
   assign DatenGespeichert = ack_schreib_q;
   assign led              = led_q;
   assign Tx               = tx_q;

endmodule

// File: tb/tb_mmio_peripheral_bus.sv
// Directed bench for mmio_peripheral_bus with TEILER=4 and an 8-deep FIFO.
module tb_mmio_peripheral_bus;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic        Auswahl = 1'b0;
   logic [1:0]  Adresse = 2'd0;
   logic        LeseDaten = 1'b0;
   logic        SchreibeDaten = 1'b0;
   logic [31:0] DatenRein = 32'd0;
   logic [31:0] DatenRaus;
   logic        DatenGeladen, DatenGespeichert;
   logic [7:0]  led;
   logic        Tx;

   int n_cmp = 0;
   int n_err = 0;

   mmio_peripheral_bus #(.CLOCK_HZ(40), .BAUD(10), .FIFO_TIEFE(8)) dut (
      .Clock(Clock), .Reset(Reset), .Auswahl(Auswahl), .Adresse(Adresse),
      .LeseDaten(LeseDaten), .SchreibeDaten(SchreibeDaten), .DatenRein(DatenRein),
      .DatenRaus(DatenRaus), .DatenGeladen(DatenGeladen), .DatenGespeichert(DatenGespeichert),
      .led(led), .Tx(Tx)
   );

   always #5 Clock = ~Clock;

   task automatic check_eq(input string tag, input logic [63:0] ist, input logic [63:0] soll);
      n_cmp++;
      if (ist !== soll) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, ist, soll);
      end
   endtask

   // One bus transaction, started at a negedge; returns one idle cycle after the ack.
   task automatic bus(input logic rd, input logic wr, input logic [1:0] adr, input logic [31:0] din,
                      output logic [31:0] dout, output logic al, output logic as, output int lat);
      Auswahl = 1'b1; LeseDaten = rd; SchreibeDaten = wr; Adresse = adr; DatenRein = din;
      lat = 0; al = 1'b0; as = 1'b0; dout = 32'd0;
      while (lat < 300 && !al && !as) begin
         @(posedge Clock); @(negedge Clock);
         lat++;
         al = DatenGeladen; as = DatenGespeichert; dout = DatenRaus;
      end
      Auswahl = 1'b0; LeseDaten = 1'b0; SchreibeDaten = 1'b0;
      @(negedge Clock);
   endtask

   // Receive one frame at mid-bit points: returns {stop, data[7:0], start}.
   task automatic empfange(output logic [9:0] frame);
      int n = 0;
      frame = 10'd0;
      while (Tx !== 1'b0 && n < 3000) begin
         @(negedge Clock); n++;
      end
      repeat (2) @(negedge Clock);
      frame[0] = Tx;
      for (int j = 1; j < 10; j++) begin
         repeat (4) @(negedge Clock);
         frame[j] = Tx;
      end
   endtask

   logic [31:0] d;
   logic        al, as;
   int          lat;
   logic [31:0] d2;
   logic        al2, as2;
   int          lat2;
   logic [9:0]  fr;
   logic [63:0] obs, expv;
   logic [9:0]  exp_frame;
   logic [7:0]  bytes [10];
   int          n, acks;
   logic        alle_eins;

   initial begin
      bytes[0] = 8'h3C; bytes[1] = 8'h01; bytes[2] = 8'h80; bytes[3] = 8'hFF; bytes[4] = 8'h00;
      bytes[5] = 8'hA7; bytes[6] = 8'h5A; bytes[7] = 8'h96; bytes[8] = 8'h42; bytes[9] = 8'hE1;

      // Reset state
      repeat (3) @(negedge Clock);
      check_eq("rst_led", {56'd0, led}, 64'h0);
      check_eq("rst_tx", {63'd0, Tx}, 64'h1);
      check_eq("rst_acks", {62'd0, DatenGeladen, DatenGespeichert}, 64'h0);
      check_eq("rst_raus", {32'd0, DatenRaus}, 64'h0);
      Reset = 1'b1;
      @(negedge Clock);

      // Status after reset: empty only, single read ack one cycle later
      bus(1'b1, 1'b0, 2'd2, 32'd0, d, al, as, lat);
      check_eq("status_rst", {32'd0, d}, 64'h2);
      check_eq("status_acks", {62'd0, al, as}, 64'h2);
      check_eq("status_lat", 64'(lat), 64'd1);

      // LED write / readback
      bus(1'b0, 1'b1, 2'd0, 32'h0000_00A5, d, al, as, lat);
      check_eq("led_wr_ack", {62'd0, al, as}, 64'h1);
      check_eq("led_wr_lat", 64'(lat), 64'd1);
      check_eq("led_val", {56'd0, led}, 64'hA5);
      bus(1'b1, 1'b0, 2'd0, 32'd0, d, al, as, lat);
      check_eq("led_rd", {32'd0, d}, 64'hA5);

      // Single 0x55 frame checked cycle by cycle
      bus(1'b0, 1'b1, 2'd1, 32'h0000_0055, d, al, as, lat);
      check_eq("uart_wr_ack", {62'd0, al, as}, 64'h1);
      n = 0;
      while (Tx !== 1'b0 && n < 100) begin
         @(negedge Clock); n++;
      end
      exp_frame = {1'b1, 8'h55, 1'b0};
      obs = 64'd0; expv = 64'd0;
      for (int k = 0; k < 40; k++) begin
         obs[k]  = Tx;
         expv[k] = exp_frame[k / 4];
         @(negedge Clock);
      end
      check_eq("frame_55", obs, expv);
      bus(1'b1, 1'b0, 2'd2, 32'd0, d, al, as, lat);
      check_eq("busy_clear", {32'd0, d}, 64'h2);

      // Ten bytes: first goes straight to the shifter, eight fill the FIFO, the last stalls
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               empfange(fr);
               check_eq($sformatf("rx_byte%0d", i), {54'd0, fr}, {54'd0, 1'b1, bytes[i], 1'b0});
            end
         end
         begin
            for (int i = 0; i < 9; i++) begin
               bus(1'b0, 1'b1, 2'd1, {24'd0, bytes[i]}, d2, al2, as2, lat2);
               check_eq($sformatf("push%0d_lat", i), 64'(lat2), 64'd1);
            end
            bus(1'b1, 1'b0, 2'd2, 32'd0, d2, al2, as2, lat2);
            check_eq("status_full", {32'd0, d2}, 64'h805);
            bus(1'b0, 1'b1, 2'd1, {24'd0, bytes[9]}, d2, al2, as2, lat2);
            check_eq("stall_ack", {62'd0, al2, as2}, 64'h1);
            check_eq("stall_held", {63'd0, (lat2 > 10 && lat2 < 60)}, 64'h1);
            bus(1'b1, 1'b0, 2'd2, 32'd0, d2, al2, as2, lat2);
            check_eq("push_pop_same", {32'd0, d2}, 64'h805);
         end
      join

      // Counter: clear, then sample later
      bus(1'b0, 1'b1, 2'd3, 32'h1234_5678, d, al, as, lat);
      check_eq("cnt_clr_ack", {62'd0, al, as}, 64'h1);
      repeat (3) @(negedge Clock);
      bus(1'b1, 1'b0, 2'd3, 32'd0, d, al, as, lat);
      check_eq("cnt_after_clr", {32'd0, d}, 64'd4);
      bus(1'b1, 1'b0, 2'd3, 32'd0, d, al, as, lat);
      check_eq("cnt_second", {32'd0, d}, 64'd6);

      // Request outside the window is ignored
      Auswahl = 1'b0; SchreibeDaten = 1'b1; Adresse = 2'd0; DatenRein = 32'h0000_003C;
      acks = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clock);
         acks += int'(DatenGeladen) + int'(DatenGespeichert);
      end
      SchreibeDaten = 1'b0;
      check_eq("nosel_acks", 64'(acks), 64'd0);
      check_eq("nosel_led", {56'd0, led}, 64'hA5);

      // Read and write together: write wins
      bus(1'b1, 1'b1, 2'd0, 32'h0000_005A, d, al, as, lat);
      check_eq("both_acks", {62'd0, al, as}, 64'h1);
      check_eq("both_led", {56'd0, led}, 64'h5A);

      // Request held high: exactly one ack
      Auswahl = 1'b1; LeseDaten = 1'b1; Adresse = 2'd0;
      acks = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge Clock);
         acks += int'(DatenGeladen);
      end
      Auswahl = 1'b0; LeseDaten = 1'b0;
      @(negedge Clock);
      check_eq("held_one_ack", 64'(acks), 64'd1);

      // Reset in the middle of a frame
      bus(1'b0, 1'b1, 2'd1, 32'h0000_0000, d, al, as, lat);
      bus(1'b0, 1'b1, 2'd1, 32'h0000_0000, d, al, as, lat);
      repeat (3) @(negedge Clock);
      check_eq("pre_rst_tx", {63'd0, Tx}, 64'h0);
      Reset = 1'b0;
      #1;
      check_eq("rst_mid_tx", {63'd0, Tx}, 64'h1);
      repeat (2) @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      bus(1'b1, 1'b0, 2'd2, 32'd0, d, al, as, lat);
      check_eq("rst_mid_status", {32'd0, d}, 64'h2);
      check_eq("rst_mid_led", {56'd0, led}, 64'h0);
      alle_eins = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge Clock);
         alle_eins = alle_eins & Tx;
      end
      check_eq("rst_mid_idle", {63'd0, alle_eins}, 64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
